regfile_wb_queue: RTL

Write-back queue that feeds the single write port of the 32×32 integer register file. It accepts results from two producers per cycle, the ALU and the load unit, and buffers them in order. It drains exactly one entry per cycle onto the register file's `reg_write`/`rd`/`write_data` inputs. It also reports whether a source register still has a pending write, so decode can stall on read-after-write hazards.

---
 rtl/regfile_wb_queue_pkg.sv | 23 ++
 rtl/regfile_wb_queue_if.sv | 42 ++++
 rtl/regfile_wb_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared definitions for the integer register file, its write-back queue
// and the decode hazard logic.
package regfile_wb_queue_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // A result only occupies the queue when it targets a real register;
    // writes to x0 are architecturally void.
    function automatic logic writes_reg(input logic                  valid,
                                        input logic [REG_ADDR_W-1:0] rd);
        return valid && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle between the producers/decode (master) and the write-back queue
// (slave). The register-file write port rides along as outputs of the queue.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = regfile_wb_queue_pkg::XLEN
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Producers
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            in_ready;
    logic            flush;

    // Hazard lookup for decode
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    // Register-file write port and status
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic [CNT_W-1:0] count;
    logic            overflow;

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, flush, rs1, rs2,
        input  in_ready, rs1_busy, rs2_busy, reg_write, rd, write_data, count, overflow
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, flush, rs1, rs2,
        output in_ready, rs1_busy, rs2_busy, reg_write, rd, write_data, count, overflow
    );

endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the single register-file write port.
// Accepts up to two results per cycle (load first, then ALU), drains one per
// cycle, and flags source registers that still have a write in flight.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = regfile_wb_queue_pkg::XLEN
) (
    input logic               clk,
    input logic               rst_n,
    regfile_wb_queue_if.slave wb_if
);
    import regfile_wb_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [XLEN-1:0]       data_mem_q [DEPTH];

    logic                  in_ready;
    logic                  accept;
    logic                  ld_push;
    logic                  alu_push;
    logic                  pop;
    logic [PTR_W-1:0]      alu_slot;
    logic [PTR_W-1:0]      rel_idx [DEPTH];
    logic [DEPTH-1:0]      occupied;
    logic [DEPTH-1:0]      hit_rs1;
    logic [DEPTH-1:0]      hit_rs2;

    // Ready only from registered occupancy, so valids never feed back into it.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign accept   = in_ready && !wb_if.flush;
    assign ld_push  = accept && writes_reg(wb_if.ld_valid,  wb_if.ld_rd);
    assign alu_push = accept && writes_reg(wb_if.alu_valid, wb_if.alu_rd);
    assign pop      = (count_q != '0);

    // The load is older, so the ALU result takes the slot after it when both push.
    assign alu_slot = tail_q + PTR_W'(ld_push);

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wb_if.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(ld_push) + PTR_W'(alu_push);
            count_d = count_q - CNT_W'(pop) + CNT_W'(ld_push) + CNT_W'(alu_push);
            if (!in_ready && (wb_if.ld_valid || wb_if.alu_valid)) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state; reset discards every queued entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; pushes write the tail slot(s) only.
    always_ff @(posedge clk) begin
        // NOTE: the entry array has no reset; an entry is only ever read while the occupancy says it is valid.
        if (ld_push) begin
            rd_mem_q[tail_q]   <= wb_if.ld_rd;
            data_mem_q[tail_q] <= wb_if.ld_data;
        end
        if (alu_push) begin
            rd_mem_q[alu_slot]   <= wb_if.alu_rd;
            data_mem_q[alu_slot] <= wb_if.alu_data;
        end
    end

    // Hazard lookup: a slot counts only if it lies within [head, head+count).
    always_comb begin
        occupied = '0;
        hit_rs1  = '0;
        hit_rs2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel_idx[i]  = PTR_W'(i) - head_q;
            occupied[i] = (CNT_W'(rel_idx[i]) < count_q);
            hit_rs1[i]  = occupied[i] && (rd_mem_q[i] == wb_if.rs1);
            hit_rs2[i]  = occupied[i] && (rd_mem_q[i] == wb_if.rs2);
        end
    end

    assign wb_if.rs1_busy   = (wb_if.rs1 != REG_ZERO) && (|hit_rs1);
    assign wb_if.rs2_busy   = (wb_if.rs2 != REG_ZERO) && (|hit_rs2);

    // The register file never stalls, so the head is presented and popped every non-empty cycle.
    assign wb_if.reg_write  = pop;
    assign wb_if.rd         = pop ? rd_mem_q[head_q]   : REG_ZERO;
    assign wb_if.write_data = pop ? data_mem_q[head_q] : '0;
    assign wb_if.in_ready   = in_ready;
    assign wb_if.count      = count_q;
    assign wb_if.overflow   = overflow_q;

endmodule
